// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
// Shared types and helpers for the decode->rename instruction queue.
//   PKT_W_DEF  : default packet width
//   BR_BIT_DEF : default bit index of the branch flag inside a packet
//   pkt_t      : packet type at the default width
//   popcount() / prefix_count() : lane counting over up to MAX_LANES lanes
// -----------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int MAX_LANES  = 16;
    localparam int PKT_W_DEF  = 128;
    localparam int BR_BIT_DEF = 100;

    typedef logic [PKT_W_DEF-1:0] pkt_t;

    // Number of set bits in v.
    function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) c = c + {4'b0, v[i]};
        return c;
    endfunction

    // Number of set bits strictly below lane k.
    function automatic logic [4:0] prefix_count(input logic [MAX_LANES-1:0] v,
                                                input int k);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++)
            if (i < k) c = c + {4'b0, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/inst_queue_param_if.sv
// -----------------------------------------------------------------------------
// inst_queue_param_if
// Bundles the decode-side write group and the rename-side dispatch group of
// the instruction queue.
//   master : decode/rename side (drives flush, stall, decode group)
//   slave  : the queue (drives stallFetch, dispatch group, counts)
// -----------------------------------------------------------------------------
interface inst_queue_param_if #(
    parameter int FETCH_WIDTH    = 8,
    parameter int DISPATCH_WIDTH = 4,
    parameter int DEPTH          = 32,
    parameter int PKT_W          = 128
);
    localparam int BC_W  = $clog2(DISPATCH_WIDTH + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                            flush_i;
    logic                            stall_i;
    logic                            decodeReady_i;
    logic [FETCH_WIDTH-1:0]          decodedVector_i;
    logic [FETCH_WIDTH*PKT_W-1:0]    decodedPacket_i;

    logic                            stallFetch_o;
    logic                            instBufferReady_o;
    logic [DISPATCH_WIDTH-1:0]       dispatchValid_o;
    logic [DISPATCH_WIDTH*PKT_W-1:0] decodedPacket_o;
    logic [BC_W-1:0]                 branchCount_o;
    logic [CNT_W-1:0]                instCount_o;

    modport master (
        output flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPacket_i,
        input  stallFetch_o, instBufferReady_o, dispatchValid_o, decodedPacket_o,
               branchCount_o, instCount_o
    );

    modport slave (
        input  flush_i, stall_i, decodeReady_i, decodedVector_i, decodedPacket_i,
        output stallFetch_o, instBufferReady_o, dispatchValid_o, decodedPacket_o,
               branchCount_o, instCount_o
    );

endinterface

// File: rtl/inst_queue_compact.sv
// -----------------------------------------------------------------------------
// inst_queue_compact
// Combinational lane compaction: each valid lane gets a write offset equal to
// the number of valid lanes below it, so a sparse group lands gap-free.
//   en_i  : group accepted this cycle
//   vec_i : per-lane valid
//   we_o  : per-lane write enable (vec_i gated by en_i)
//   off_o : per-lane offset from the tail
//   n_o   : number of lanes written (0 when not enabled)
// -----------------------------------------------------------------------------
module inst_queue_compact
    import inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = 8
) (
    input  logic                        en_i,
    input  logic [FETCH_WIDTH-1:0]      vec_i,
    output logic [FETCH_WIDTH-1:0]      we_o,
    output logic [FETCH_WIDTH-1:0][4:0] off_o,
    output logic [4:0]                  n_o
);

    logic [MAX_LANES-1:0] vec_ext;

    assign vec_ext = MAX_LANES'(vec_i);
    assign we_o    = en_i ? vec_i : '0;
    assign n_o     = en_i ? popcount(vec_ext) : 5'd0;

    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_off
        assign off_o[k] = prefix_count(vec_ext, k);
    end

endmodule

// File: rtl/inst_queue_param.sv
// -----------------------------------------------------------------------------
// inst_queue_param
// Decoupling queue between decode and rename. Up to FETCH_WIDTH sparse lanes
// are compacted into a circular buffer each cycle; up to DISPATCH_WIDTH
// entries are presented in order from the head.
//   clk, reset : clock, synchronous active-high reset
//   q (slave)  : flush/stall, decode write group, dispatch group,
//                branch count and registered occupancy
// Optional build macro: INST_QUEUE_PARTIAL_DISPATCH_EN
//   defined   -> dispatch whenever at least one entry is present, consuming
//                min(count, DISPATCH_WIDTH)
//   undefined -> all-or-nothing dispatch of DISPATCH_WIDTH entries
// -----------------------------------------------------------------------------
module inst_queue_param
    import inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH    = 8,
    parameter int DISPATCH_WIDTH = 4,
    parameter int DEPTH          = 32,
    parameter int PKT_W          = PKT_W_DEF,
    parameter int BR_BIT         = BR_BIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    inst_queue_param_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DISPATCH_WIDTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic                        stall_fetch;
    logic                        wr;
    logic                        ready;
    logic                        deq;
    logic [CNT_W-1:0]            n_in;
    logic [CNT_W-1:0]            n_out;
    logic [CNT_W-1:0]            n_avail;
    logic [4:0]                  n_in_raw;
    logic [FETCH_WIDTH-1:0]      lane_we;
    logic [FETCH_WIDTH-1:0][4:0] lane_off;

    logic [DISPATCH_WIDTH-1:0][PTR_W-1:0] rd_addr;
    logic [DISPATCH_WIDTH-1:0]            slot_vld;
    logic [BC_W-1:0]                      br_cnt;

    // Room for a whole group is guaranteed whenever this is low.
    assign stall_fetch = count_q > CNT_W'(DEPTH - FETCH_WIDTH);
    assign wr          = q.decodeReady_i & ~stall_fetch;

    inst_queue_compact #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_compact (
        .en_i  (wr),
        .vec_i (q.decodedVector_i),
        .we_o  (lane_we),
        .off_o (lane_off),
        .n_o   (n_in_raw)
    );

    assign n_in    = CNT_W'(n_in_raw);
    assign n_avail = (count_q < CNT_W'(DISPATCH_WIDTH)) ? count_q : CNT_W'(DISPATCH_WIDTH);

`ifdef INST_QUEUE_PARTIAL_DISPATCH_EN
    assign ready = (count_q != '0);
    assign n_out = n_avail;
`else
    assign ready = (count_q >= CNT_W'(DISPATCH_WIDTH));
    assign n_out = CNT_W'(DISPATCH_WIDTH);
`endif

    assign deq = ~q.stall_i & ready;

    // Pointer/count next state; flush drops everything including this
    // cycle's write and dispatch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            tail_d  = tail_q + PTR_W'(n_in);
            if (deq) head_d = head_q + PTR_W'(n_out);
            count_d = count_q + n_in - (deq ? n_out : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (!reset && !q.flush_i) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (lane_we[k])
                    mem_q[tail_q + PTR_W'(lane_off[k])] <= q.decodedPacket_i[k*PKT_W +: PKT_W];
            end
        end
    end

    // Read ports: combinational from the head, wrapping naturally via PTR_W.
    for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_rd
        assign rd_addr[j]  = head_q + PTR_W'(j);
        assign slot_vld[j] = ready & (CNT_W'(j) < n_avail);
        assign q.decodedPacket_o[j*PKT_W +: PKT_W] = mem_q[rd_addr[j]];
    end

    // Only valid slots may contribute; stale storage in idle slots is ignored.
    always_comb begin
        br_cnt = '0;
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
            if (slot_vld[j] && mem_q[rd_addr[j]][BR_BIT]) br_cnt = br_cnt + BC_W'(1);
        end
    end

    assign q.stallFetch_o      = stall_fetch;
    assign q.instBufferReady_o = ready;
    assign q.dispatchValid_o   = slot_vld;
    assign q.branchCount_o     = br_cnt;
    assign q.instCount_o       = count_q;

endmodule

// File: tb/tb_inst_queue_param.sv
module tb_inst_queue_param;
    import inst_queue_pkg::*;

    localparam int FW    = 8;
    localparam int DW    = 4;
    localparam int DEPTH = 32;
    localparam int PW    = 128;
    localparam int BR    = 100;
`ifdef INST_QUEUE_PARTIAL_DISPATCH_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_queue_param_if #(.FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW)) bus();

    inst_queue_param #(
        .FETCH_WIDTH(FW), .DISPATCH_WIDTH(DW), .DEPTH(DEPTH), .PKT_W(PW), .BR_BIT(BR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    // Reference: the queue contents in order, oldest first.
    pkt_t          mdl[$];
    bit            mdl_ok   = 1'b0;
    int            n_chk    = 0;
    int            n_err    = 0;
    bit            force_br = 1'b0;
    logic [FW-1:0] br_pat   = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t rnd_pkt();
        pkt_t p;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        return p;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cyc(input bit rst, input bit fl, input bit st, input bit dr,
                       input logic [FW-1:0] vec);
        pkt_t lanes[FW];
        int   sz, nav, br;
        bit   rdy, stf, v;
        @(negedge clk);
        reset              = rst;
        bus.flush_i        = fl;
        bus.stall_i        = st;
        bus.decodeReady_i  = dr;
        bus.decodedVector_i = vec;
        for (int k = 0; k < FW; k++) begin
            lanes[k] = rnd_pkt();
            if (force_br) lanes[k][BR] = br_pat[k];
            bus.decodedPacket_i[k*PW +: PW] = lanes[k];
        end
        #1;
        sz  = mdl.size();
        stf = (sz > DEPTH - FW);
        rdy = PARTIAL ? (sz >= 1) : (sz >= DW);
        nav = (sz < DW) ? sz : DW;
        if (mdl_ok) begin
            chk("count", 128'(bus.instCount_o), 128'(sz));
            chk("stallFetch", 128'(bus.stallFetch_o), 128'(stf));
            chk("ready", 128'(bus.instBufferReady_o), 128'(rdy));
            br = 0;
            for (int j = 0; j < DW; j++) begin
                v = rdy && (j < nav);
                chk($sformatf("valid%0d", j), 128'(bus.dispatchValid_o[j]), 128'(v));
                if (v) begin
                    chk($sformatf("slot%0d", j), bus.decodedPacket_o[j*PW +: PW], mdl[j]);
                    if (mdl[j][BR]) br++;
                end
            end
            chk("branchCount", 128'(bus.branchCount_o), 128'(br));
        end
        if (rst || fl) begin
            mdl.delete();
        end else begin
            if (!st && rdy) begin
                for (int j = 0; j < (PARTIAL ? nav : DW); j++) mdl.delete(0);
            end
            if (dr && !stf) begin
                for (int k = 0; k < FW; k++) if (vec[k]) mdl.push_back(lanes[k]);
            end
        end
        if (rst) mdl_ok = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [FW-1:0] v;
        reset               = 1'b1;
        bus.flush_i         = 1'b0;
        bus.stall_i         = 1'b0;
        bus.decodeReady_i   = 1'b0;
        bus.decodedVector_i = '0;
        bus.decodedPacket_i = '0;
        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);

        // Full group while downstream stalls.
        cyc(0, 0, 1, 1, 8'hFF);
        #1 chk("full_cnt", 128'(bus.instCount_o), 128'd8);
        chk("full_rdy", 128'(bus.instBufferReady_o), 128'd1);

        // Sparse group compacts gap-free.
        cyc(0, 1, 1, 0, '0);
        cyc(0, 0, 1, 1, 8'b1010_0101);
        #1 chk("sparse_cnt", 128'(bus.instCount_o), 128'd4);
        cyc(0, 0, 1, 0, '0);

        // Fill to 25: fetch must stall and further groups are dropped.
        cyc(0, 1, 1, 0, '0);
        repeat (3) cyc(0, 0, 1, 1, 8'hFF);
        cyc(0, 0, 1, 1, 8'h01);
        #1 chk("fill_cnt", 128'(bus.instCount_o), 128'd25);
        chk("fill_stf", 128'(bus.stallFetch_o), 128'd1);
        cyc(0, 0, 1, 1, 8'hFF);
        #1 chk("drop_cnt", 128'(bus.instCount_o), 128'd25);
        cyc(0, 0, 0, 0, '0);
        #1 chk("drain_cnt", 128'(bus.instCount_o), 128'd21);
        chk("drain_stf", 128'(bus.stallFetch_o), 128'd0);

        // Advance pointers toward the end of the array, leave count=2.
        cyc(0, 1, 1, 0, '0);
        repeat (3) cyc(0, 0, 1, 1, 8'hFF);
        cyc(0, 0, 1, 1, 8'h3F);
        repeat (7) cyc(0, 0, 0, 0, '0);
        #1 chk("two_cnt", 128'(bus.instCount_o), 128'd2);
        cyc(0, 0, 0, 0, '0);
        #1 chk("two_after", 128'(bus.instCount_o), PARTIAL ? 128'd0 : 128'd2);

        // Top up to 6 (wraps the tail), then write 3 while dispatching 4.
        v = FW'((1 << (6 - mdl.size())) - 1);
        cyc(0, 0, 1, 1, v);
        cyc(0, 0, 0, 1, 8'h07);
        #1 chk("wr3_rd4", 128'(bus.instCount_o), 128'd5);

        // Flush wins over a simultaneous write and dispatch.
        cyc(0, 1, 0, 1, 8'hFF);
        #1 chk("flush_cnt", 128'(bus.instCount_o), 128'd0);
        chk("flush_rdy", 128'(bus.instBufferReady_o), 128'd0);
        chk("flush_vld", 128'(bus.dispatchValid_o), 128'd0);
        force_br = 1'b1;
        br_pat   = 8'h05;
        cyc(0, 0, 1, 1, 8'h0F);
        force_br = 1'b0;
        #1 chk("br_cnt", 128'(bus.branchCount_o), 128'd2);
        chk("br_vld", 128'(bus.dispatchValid_o), 128'hF);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            bit r, f, s, d;
            r = ($urandom_range(0, 149) == 0);
            f = ($urandom_range(0, 39) == 0);
            s = (i < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 3) != 0);
            cyc(r, f, s, d, FW'($urandom()));
        end

        // Reset mid-operation drops everything.
        cyc(0, 0, 1, 1, 8'hFF);
        cyc(1, 0, 0, 1, 8'hFF);
        #1 chk("rst_cnt", 128'(bus.instCount_o), 128'd0);
        chk("rst_vld", 128'(bus.dispatchValid_o), 128'd0);
        cyc(0, 0, 0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue_param.md
# inst_queue_param

Parametrised decoupling queue between decode and rename. It accepts up to FETCH_WIDTH decoded packets per cycle, with a sparse valid vector, and compacts them into a circular buffer. It presents up to DISPATCH_WIDTH packets in order from the head, together with per-slot valid bits and a branch count. It supersedes the fixed 8-in/4-out instruction buffer by adding generic widths and depth, gap-free compaction, an occupancy output and an optional partial-dispatch mode.

## Interface
Parameters:
- FETCH_WIDTH, 8, max packets written per cycle (1..16)
- DISPATCH_WIDTH, 4, max packets read per cycle (1..FETCH_WIDTH)
- DEPTH, 32, entries; power of two, ≥ 2*FETCH_WIDTH
- PKT_W, 128, packet width in bits
- BR_BIT, 100, bit index of the branch flag inside a packet

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- flush_i  in  1  mispredict flush; empties the queue
- stall_i  in  1  downstream cannot accept this cycle
- decodeReady_i  in  1  input group is valid
- decodedVector_i  in  FETCH_WIDTH  per-lane valid; any pattern, gaps allowed
- decodedPacket_i  in  FETCH_WIDTH*PKT_W  lane k at bits [k*PKT_W +: PKT_W]
- stallFetch_o  out  1  queue cannot guarantee room for a full group
- instBufferReady_o  out  1  a dispatch group is available this cycle
- dispatchValid_o  out  DISPATCH_WIDTH  per-slot valid
- decodedPacket_o  out  DISPATCH_WIDTH*PKT_W  slot j = entry head+j
- branchCount_o  out  $clog2(DISPATCH_WIDTH+1)  count of valid slots with BR_BIT set
- instCount_o  out  $clog2(DEPTH+1)  current occupancy (registered)

## Operation
- State: headPtr and tailPtr, each log2(DEPTH) bits and wrapping modulo DEPTH; count, log2(DEPTH)+1 bits; storage array of DEPTH x PKT_W.
- stallFetch_o = (count > DEPTH − FETCH_WIDTH). It is a function of registered count only.
- Write acceptance: wr = decodeReady_i & ~stallFetch_o. When wr is low, nothing is written, even if lanes are valid.
- Compaction: valid lane k writes to tailPtr + (number of valid lanes below k). nIn = popcount(decodedVector_i) when wr, else 0. The tail advances by nIn.
- Dispatch: deq = ~stall_i & instBufferReady_o.
  - Without PARTIAL_DISPATCH_EN: instBufferReady_o = (count ≥ DISPATCH_WIDTH); nOut = DISPATCH_WIDTH.
  - With PARTIAL_DISPATCH_EN, see Configuration.
  - The head advances by nOut when deq, else by 0.
- Next count = count + nIn − (deq ? nOut : 0). Writes and reads in the same cycle are legal. Write room is guaranteed by stallFetch_o, so overflow cannot occur. Underflow is impossible by construction.
- Read data is combinational from storage at headPtr+j (wrapped). dispatchValid_o[j] = (j < min(count, DISPATCH_WIDTH)) & instBufferReady_o.
- Invalid slots: decodedPacket_o content is don't-care, but these slots must not contribute to branchCount_o.
- Priority: reset > flush_i > normal. Under reset or flush: headPtr = tailPtr = count = 0, and any writes that cycle are discarded. Storage contents are not cleared.
- Reset or flush arriving mid-operation drops every entry, including any group being dispatched that cycle. Downstream must ignore that group.

## Timing
- Write-to-visible latency: 1 cycle. A packet written at edge N can appear on decodedPacket_o in cycle N+1.
- There is no read/write bypass. An empty queue gives no output in the same cycle it is written.
- Handshake: a group is consumed on a cycle where instBufferReady_o=1 and stall_i=0. Outputs hold stable while stall_i=1.
- Values after reset:
  - stallFetch_o = 0
  - instBufferReady_o = 0
  - dispatchValid_o = 0
  - branchCount_o = 0
  - instCount_o = 0
  - decodedPacket_o is X/don't-care
- Pointer wrap: DEPTH−1 + 1 → 0. Compaction and read addresses also wrap across the end of the array.

## Configuration
- Macro: INST_QUEUE_PARTIAL_DISPATCH_EN.
- Defined:
  - instBufferReady_o = (count ≥ 1).
  - nOut = min(count, DISPATCH_WIDTH).
  - dispatchValid_o marks the leading slots only.
- Undefined: all-or-nothing dispatch. instBufferReady_o requires count ≥ DISPATCH_WIDTH, and dispatchValid_o is all-ones or all-zeros.

## Structure
- Shared package inst_queue_pkg holds:
  - the packet typedef, sized by PKT_W
  - the BR_BIT constant
  - the popcount function
  - the prefix-count function
- Sub-module inst_queue_compact: combinational prefix-sum that maps FETCH_WIDTH lanes to write offsets plus per-lane enables. It is instantiated once.
- Storage is a flop array inside the top module: FETCH_WIDTH write ports, DISPATCH_WIDTH read ports.

## Test plan
- Reset, then vector 8'hFF with decodeReady=1 for one cycle and stall_i=1.
  - Required: next cycle instCount_o=8 and instBufferReady_o=1.
  - Required: slots hold lanes 0..3 in order.
- Sparse vector 8'b1010_0101 into an empty queue.
  - Required: count=4.
  - Required: slots 0..3 equal lanes 0, 2, 5, 7, with no gaps.
- Fill to count=25 with DEPTH=32.
  - Required: stallFetch_o=1, and a further vector 8'hFF leaves count at 25.
  - Then release stall_i and dispatch.
  - Required: count drops to 21 and stallFetch_o falls.
- Simultaneous write of 3 and dispatch of 4 from count=6.
  - Required: count=5 next cycle.
  - Required: head and tail wrap correctly when started at pointer 30.
- Count=2 with stall_i=0.
  - Macro undefined: instBufferReady_o=0 and count stays 2.
  - Macro defined: dispatchValid_o=4'b0011, and count becomes 0.
- flush_i asserted together with a write of 8 and a dispatch.
  - Required: next cycle count=0, ready=0, and all-zero valid vector.
  - Required: a following write appears at entry 0.
  - Required: branchCount_o equals the number of branch-flagged valid slots (e.g. 2 for flags 4'b0101).
